// File: rtl/lsu_ctrl_resp.sv
// In-order load/store control: issues AGU commands on the data bus, tracks outstanding
// transactions and returns aligned, extended load results. Optional misalign trap: LSU_MISALIGN_CHK_EN.
module lsu_ctrl_resp #(
  parameter int XLEN       = 32,
  parameter int ADDR_SIZE  = 32,
  parameter int ITAG_WIDTH = 2,
  parameter int OUTS_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  agu_cmd_valid,
  output logic                  agu_cmd_ready,
  input  logic [ADDR_SIZE-1:0]  agu_cmd_addr,
  input  logic                  agu_cmd_read,
  input  logic [XLEN-1:0]       agu_cmd_wdata,
  input  logic [XLEN/8-1:0]     agu_cmd_wmask,
  input  logic [1:0]            agu_cmd_size,
  input  logic                  agu_cmd_usign,
  input  logic [ITAG_WIDTH-1:0] agu_cmd_itag,
  output logic                  agu_rsp_valid,
  input  logic                  agu_rsp_ready,
  output logic                  dbus_cmd_valid,
  input  logic                  dbus_cmd_ready,
  output logic [ADDR_SIZE-1:0]  dbus_cmd_addr,
  output logic                  dbus_cmd_read,
  output logic [XLEN-1:0]       dbus_cmd_wdata,
  output logic [XLEN/8-1:0]     dbus_cmd_wmask,
  input  logic                  dbus_rsp_valid,
  output logic                  dbus_rsp_ready,
  input  logic [XLEN-1:0]       dbus_rsp_rdata,
  input  logic                  dbus_rsp_err,
  output logic                  lsu_o_valid,
  input  logic                  lsu_o_ready,
  output logic [XLEN-1:0]       lsu_o_wbck_wdat,
  output logic [ITAG_WIDTH-1:0] lsu_o_itag,
  output logic                  lsu_o_err,
  output logic                  lsu_o_misalgn,
  output logic [ADDR_SIZE-1:0]  lsu_o_badaddr
);

  localparam int IDX_W  = $clog2(OUTS_DEPTH);
  localparam int PTR_W  = IDX_W + 1;
  localparam int IDX_WS = (IDX_W == 0) ? 1 : IDX_W;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [IDX_WS-1:0] wr_idx, rd_idx;
  logic              fifo_full, fifo_empty;

  logic              local_cmd;
  logic              push, pop;
  logic              head_local;
  logic              wb_free, rsp_hs, wb_load;

  logic [ITAG_WIDTH-1:0] ent_itag_q  [OUTS_DEPTH];
  logic                  ent_read_q  [OUTS_DEPTH];
  logic [1:0]            ent_size_q  [OUTS_DEPTH];
  logic                  ent_usign_q [OUTS_DEPTH];
  logic [1:0]            ent_off_q   [OUTS_DEPTH];

  logic [ITAG_WIDTH-1:0] head_itag;
  logic                  head_read;
  logic [1:0]            head_size;
  logic                  head_usign;
  logic [1:0]            head_off;

  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_res;

  logic                  wb_valid_q, wb_valid_d;
  logic [XLEN-1:0]       wb_wdat_q, wb_wdat_d;
  logic [ITAG_WIDTH-1:0] wb_itag_q, wb_itag_d;
  logic                  wb_err_q, wb_err_d;
  logic                  wb_misalgn_q, wb_misalgn_d;
  logic [ADDR_SIZE-1:0]  wb_badaddr_q, wb_badaddr_d;

  logic unused_inputs;
  assign unused_inputs = agu_rsp_ready;

  // Depth 1 has no index bits: the single pointer bit alone tells full from empty.
  generate
    if (IDX_W == 0) begin : g_ptr_d1
      assign wr_idx    = '0;
      assign rd_idx    = '0;
      assign fifo_full = (wr_ptr_q[0] != rd_ptr_q[0]);
    end else begin : g_ptr_dn
      assign wr_idx    = wr_ptr_q[IDX_W-1:0];
      assign rd_idx    = rd_ptr_q[IDX_W-1:0];
      assign fifo_full = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) && (wr_idx == rd_idx);
    end
  endgenerate

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);

`ifdef LSU_MISALIGN_CHK_EN
  logic                 ent_local_q [OUTS_DEPTH];
  logic [ADDR_SIZE-1:0] ent_addr_q  [OUTS_DEPTH];
  logic [ADDR_SIZE-1:0] head_addr;

  always_comb begin
    local_cmd = 1'b0;
    case (agu_cmd_size)
      2'b01:   local_cmd = agu_cmd_addr[0];
      2'b10:   local_cmd = (agu_cmd_addr[1:0] != 2'b00);
      default: local_cmd = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_local_q[wr_idx] <= local_cmd;
      ent_addr_q[wr_idx]  <= agu_cmd_addr;
    end
  end

  assign head_local = ~fifo_empty & ent_local_q[rd_idx];
  assign head_addr  = ent_addr_q[rd_idx];
`else
  assign local_cmd  = 1'b0;
  assign head_local = 1'b0;
`endif

  // Command path is purely combinational; a full FIFO blocks even if a pop is under way.
  assign dbus_cmd_valid = agu_cmd_valid & ~fifo_full & ~local_cmd;
  assign agu_cmd_ready  = ~fifo_full & (dbus_cmd_ready | local_cmd);
  assign dbus_cmd_addr  = {agu_cmd_addr[ADDR_SIZE-1:2], 2'b00};
  assign dbus_cmd_read  = agu_cmd_read;
  assign dbus_cmd_wdata = agu_cmd_wdata;
  assign dbus_cmd_wmask = agu_cmd_wmask;
  assign push           = agu_cmd_valid & agu_cmd_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      ent_itag_q[wr_idx]  <= agu_cmd_itag;
      ent_read_q[wr_idx]  <= agu_cmd_read;
      ent_size_q[wr_idx]  <= agu_cmd_size;
      ent_usign_q[wr_idx] <= agu_cmd_usign;
      ent_off_q[wr_idx]   <= agu_cmd_addr[1:0];
    end
  end

  assign head_itag  = ent_itag_q[rd_idx];
  assign head_read  = ent_read_q[rd_idx];
  assign head_size  = ent_size_q[rd_idx];
  assign head_usign = ent_usign_q[rd_idx];
  assign head_off   = ent_off_q[rd_idx];

  // Responses with an empty FIFO are still accepted so a stale beat cannot wedge the bus.
  assign wb_free        = ~wb_valid_q | lsu_o_ready;
  assign dbus_rsp_ready = wb_free & ~head_local;
  assign rsp_hs         = dbus_rsp_valid & dbus_rsp_ready;
  assign agu_rsp_valid  = rsp_hs & ~fifo_empty;
  assign wb_load        = agu_rsp_valid | (head_local & wb_free);
  assign pop            = wb_load;

  assign wr_ptr_d = wr_ptr_q + PTR_W'(push);
  assign rd_ptr_d = rd_ptr_q + PTR_W'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign ld_byte = 8'(dbus_rsp_rdata >> {head_off, 3'b000});
  assign ld_half = 16'(dbus_rsp_rdata >> {head_off[1], 4'b0000});

  always_comb begin
    ld_res = '0;
    case (head_size)
      2'b00:   ld_res = {{(XLEN-8){~head_usign & ld_byte[7]}}, ld_byte};
      2'b01:   ld_res = {{(XLEN-16){~head_usign & ld_half[15]}}, ld_half};
      default: ld_res = dbus_rsp_rdata;
    endcase
    if (!head_read) begin
      ld_res = '0;
    end
  end

  always_comb begin
    wb_valid_d   = wb_valid_q;
    wb_wdat_d    = wb_wdat_q;
    wb_itag_d    = wb_itag_q;
    wb_err_d     = wb_err_q;
    wb_misalgn_d = wb_misalgn_q;
    wb_badaddr_d = wb_badaddr_q;
    if (lsu_o_ready) begin
      wb_valid_d = 1'b0;
    end
    if (wb_load) begin
      wb_valid_d   = 1'b1;
      wb_itag_d    = head_itag;
      wb_wdat_d    = ld_res;
      wb_err_d     = dbus_rsp_err;
      wb_misalgn_d = 1'b0;
      wb_badaddr_d = '0;
`ifdef LSU_MISALIGN_CHK_EN
      if (head_local) begin
        wb_wdat_d    = '0;
        wb_err_d     = 1'b1;
        wb_misalgn_d = 1'b1;
        wb_badaddr_d = head_addr;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q   <= 1'b0;
      wb_wdat_q    <= '0;
      wb_itag_q    <= '0;
      wb_err_q     <= 1'b0;
      wb_misalgn_q <= 1'b0;
      wb_badaddr_q <= '0;
    end else begin
      wb_valid_q   <= wb_valid_d;
      wb_wdat_q    <= wb_wdat_d;
      wb_itag_q    <= wb_itag_d;
      wb_err_q     <= wb_err_d;
      wb_misalgn_q <= wb_misalgn_d;
      wb_badaddr_q <= wb_badaddr_d;
    end
  end

  assign lsu_o_valid     = wb_valid_q;
  assign lsu_o_wbck_wdat = wb_wdat_q;
  assign lsu_o_itag      = wb_itag_q;
  assign lsu_o_err       = wb_err_q;
  assign lsu_o_misalgn   = wb_misalgn_q;
  assign lsu_o_badaddr   = wb_badaddr_q;

endmodule

// File: tb/tb_lsu_ctrl_resp.sv
// Directed scoreboard bench for lsu_ctrl_resp: expected write-backs are queued when a
// bus response is driven and compared as the write-back port hands them over.
module tb_lsu_ctrl_resp;

  logic        clk;
  logic        rst;
  logic        agu_cmd_valid;
  logic        agu_cmd_ready;
  logic [31:0] agu_cmd_addr;
  logic        agu_cmd_read;
  logic [31:0] agu_cmd_wdata;
  logic [3:0]  agu_cmd_wmask;
  logic [1:0]  agu_cmd_size;
  logic        agu_cmd_usign;
  logic [1:0]  agu_cmd_itag;
  logic        agu_rsp_valid;
  logic        agu_rsp_ready;
  logic        dbus_cmd_valid;
  logic        dbus_cmd_ready;
  logic [31:0] dbus_cmd_addr;
  logic        dbus_cmd_read;
  logic [31:0] dbus_cmd_wdata;
  logic [3:0]  dbus_cmd_wmask;
  logic        dbus_rsp_valid;
  logic        dbus_rsp_ready;
  logic [31:0] dbus_rsp_rdata;
  logic        dbus_rsp_err;
  logic        lsu_o_valid;
  logic        lsu_o_ready;
  logic [31:0] lsu_o_wbck_wdat;
  logic [1:0]  lsu_o_itag;
  logic        lsu_o_err;
  logic        lsu_o_misalgn;
  logic [31:0] lsu_o_badaddr;

  lsu_ctrl_resp #(.XLEN(32), .ADDR_SIZE(32), .ITAG_WIDTH(2), .OUTS_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .agu_cmd_valid(agu_cmd_valid), .agu_cmd_ready(agu_cmd_ready), .agu_cmd_addr(agu_cmd_addr),
    .agu_cmd_read(agu_cmd_read), .agu_cmd_wdata(agu_cmd_wdata), .agu_cmd_wmask(agu_cmd_wmask),
    .agu_cmd_size(agu_cmd_size), .agu_cmd_usign(agu_cmd_usign), .agu_cmd_itag(agu_cmd_itag),
    .agu_rsp_valid(agu_rsp_valid), .agu_rsp_ready(agu_rsp_ready),
    .dbus_cmd_valid(dbus_cmd_valid), .dbus_cmd_ready(dbus_cmd_ready), .dbus_cmd_addr(dbus_cmd_addr),
    .dbus_cmd_read(dbus_cmd_read), .dbus_cmd_wdata(dbus_cmd_wdata), .dbus_cmd_wmask(dbus_cmd_wmask),
    .dbus_rsp_valid(dbus_rsp_valid), .dbus_rsp_ready(dbus_rsp_ready), .dbus_rsp_rdata(dbus_rsp_rdata),
    .dbus_rsp_err(dbus_rsp_err),
    .lsu_o_valid(lsu_o_valid), .lsu_o_ready(lsu_o_ready), .lsu_o_wbck_wdat(lsu_o_wbck_wdat),
    .lsu_o_itag(lsu_o_itag), .lsu_o_err(lsu_o_err), .lsu_o_misalgn(lsu_o_misalgn),
    .lsu_o_badaddr(lsu_o_badaddr)
  );

  typedef struct packed {
    logic [31:0] wdat;
    logic [1:0]  itag;
    logic        err;
    logic        mis;
    logic [31:0] bad;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   pulses = 0;

  // Values sampled at the falling edge, i.e. what the next rising edge will act on.
  logic        s_cmd_rdy, s_dcmd_valid, s_dcmd_read, s_drsp_rdy;
  logic [31:0] s_dcmd_addr, s_dcmd_wdata;
  logic [3:0]  s_dcmd_wmask;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] rdata, input logic [1:0] off,
                                        input logic [1:0] size, input logic usign, input logic rd);
    logic [7:0]  b;
    logic [15:0] h;
    if (!rd) return 32'h0;
    case (off)
      2'd0: b = rdata[7:0];
      2'd1: b = rdata[15:8];
      2'd2: b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    if (size == 2'b00) return usign ? {24'h0, b} : {{24{b[7]}}, b};
    if (size == 2'b01) return usign ? {16'h0, h} : {{16{h[15]}}, h};
    return rdata;
  endfunction

  function automatic exp_t mk(input logic [31:0] w, input logic [1:0] t, input logic e,
                              input logic m, input logic [31:0] a);
    exp_t r;
    r.wdat = w; r.itag = t; r.err = e; r.mis = m; r.bad = a;
    return r;
  endfunction

  task automatic tick();
    exp_t e;
    @(negedge clk);
    s_cmd_rdy    = agu_cmd_valid & agu_cmd_ready;
    s_dcmd_valid = dbus_cmd_valid;
    s_dcmd_addr  = dbus_cmd_addr;
    s_dcmd_read  = dbus_cmd_read;
    s_dcmd_wdata = dbus_cmd_wdata;
    s_dcmd_wmask = dbus_cmd_wmask;
    s_drsp_rdy   = dbus_rsp_ready;
    if (agu_rsp_valid) pulses++;
    if (lsu_o_valid && lsu_o_ready) begin
      chk("wb_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        $display("wb itag=%0d wdat=%h err=%0d mis=%0d bad=%h", lsu_o_itag, lsu_o_wbck_wdat,
                 lsu_o_err, lsu_o_misalgn, lsu_o_badaddr);
        chk("wb_wdat", lsu_o_wbck_wdat, e.wdat);
        chk("wb_itag", 32'(lsu_o_itag), 32'(e.itag));
        chk("wb_err", 32'(lsu_o_err), 32'(e.err));
        chk("wb_misalgn", 32'(lsu_o_misalgn), 32'(e.mis));
        chk("wb_badaddr", lsu_o_badaddr, e.bad);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [31:0] addr, input logic rd, input logic [31:0] wdata,
                          input logic [3:0] wmask, input logic [1:0] size, input logic usign,
                          input logic [1:0] itag);
    logic ok;
    agu_cmd_valid = 1'b1; agu_cmd_addr = addr; agu_cmd_read = rd; agu_cmd_wdata = wdata;
    agu_cmd_wmask = wmask; agu_cmd_size = size; agu_cmd_usign = usign; agu_cmd_itag = itag;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_cmd_rdy) begin ok = 1'b1; break; end
    end
    agu_cmd_valid = 1'b0;
    $display("cmd addr=%h rd=%0d size=%0d itag=%0d bus_valid=%0d", addr, rd, size, itag, s_dcmd_valid);
    chk("cmd_accepted", 32'(ok), 32'd1);
  endtask

  task automatic respond(input logic [31:0] rdata, input logic err, input exp_t e);
    logic ok;
    dbus_rsp_valid = 1'b1; dbus_rsp_rdata = rdata; dbus_rsp_err = err;
    exp_q.push_back(e);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_drsp_rdy) begin ok = 1'b1; break; end
    end
    dbus_rsp_valid = 1'b0;
    $display("rsp rdata=%h err=%0d", rdata, err);
    chk("rsp_accepted", 32'(ok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    rst = 1'b1; agu_cmd_valid = 1'b0; agu_cmd_addr = '0; agu_cmd_read = 1'b0;
    agu_cmd_wdata = '0; agu_cmd_wmask = '0; agu_cmd_size = '0; agu_cmd_usign = 1'b0;
    agu_cmd_itag = '0; agu_rsp_ready = 1'b1; dbus_cmd_ready = 1'b0; dbus_rsp_valid = 1'b0;
    dbus_rsp_rdata = '0; dbus_rsp_err = 1'b0; lsu_o_ready = 1'b1;
    repeat (3) tick();

    // Reset values
    chk("rst_valid", 32'(lsu_o_valid), 32'd0);
    chk("rst_wdat", lsu_o_wbck_wdat, 32'd0);
    chk("rst_itag", 32'(lsu_o_itag), 32'd0);
    chk("rst_err", 32'(lsu_o_err), 32'd0);
    chk("rst_misalgn", 32'(lsu_o_misalgn), 32'd0);
    chk("rst_badaddr", lsu_o_badaddr, 32'd0);
    chk("rst_cmd_rdy_busy", 32'(agu_cmd_ready), 32'd0);
    rst = 1'b0; dbus_cmd_ready = 1'b1;
    tick();
    chk("cmd_rdy_follows_bus", 32'(agu_cmd_ready), 32'd1);

    // LB with sign extension, one cycle latency
    send_cmd(32'h1003, 1'b1, 32'h0, 4'h0, 2'b00, 1'b0, 2'd1);
    chk("lb_bus_addr", s_dcmd_addr, 32'h1000);
    chk("lb_bus_valid", 32'(s_dcmd_valid), 32'd1);
    respond(32'h80FF_0000, 1'b0, mk(model(32'h80FF_0000, 2'd3, 2'b00, 1'b0, 1'b1), 2'd1, 1'b0, 1'b0, 32'h0));
    chk("lb_latency", 32'(lsu_o_valid), 32'd1);
    chk("lb_wdat_direct", lsu_o_wbck_wdat, 32'hFFFF_FF80);
    tick();

    // LHU / LH
    send_cmd(32'h2002, 1'b1, 32'h0, 4'h0, 2'b01, 1'b1, 2'd2);
    respond(32'hBEEF_1234, 1'b0, mk(32'h0000_BEEF, 2'd2, 1'b0, 1'b0, 32'h0));
    send_cmd(32'h2002, 1'b1, 32'h0, 4'h0, 2'b01, 1'b0, 2'd3);
    respond(32'hBEEF_1234, 1'b0, mk(32'hFFFF_BEEF, 2'd3, 1'b0, 1'b0, 32'h0));
    tick();

    // SW with bus error
    send_cmd(32'h3000, 1'b0, 32'hDEAD_BEEF, 4'hF, 2'b10, 1'b0, 2'd2);
    chk("sw_bus_wdata", s_dcmd_wdata, 32'hDEAD_BEEF);
    chk("sw_bus_wmask", 32'(s_dcmd_wmask), 32'hF);
    chk("sw_bus_read", 32'(s_dcmd_read), 32'd0);
    p0 = pulses;
    respond(32'h1234_5678, 1'b1, mk(32'h0, 2'd2, 1'b1, 1'b0, 32'h0));
    tick(); tick();
    chk("sw_agu_rsp_pulses", 32'(pulses - p0), 32'd1);

    // Outstanding limit, in-order return, write-back backpressure
    send_cmd(32'h5000, 1'b1, 32'h0, 4'h0, 2'b10, 1'b0, 2'd0);
    send_cmd(32'h5004, 1'b1, 32'h0, 4'h0, 2'b10, 1'b0, 2'd1);
    agu_cmd_valid = 1'b1; agu_cmd_addr = 32'h5009; agu_cmd_read = 1'b1; agu_cmd_size = 2'b00;
    agu_cmd_usign = 1'b1; agu_cmd_itag = 2'd2;
    tick();
    chk("full_stall_rdy", 32'(s_cmd_rdy), 32'd0);
    chk("full_stall_bus", 32'(s_dcmd_valid), 32'd0);
    respond(32'h1122_3344, 1'b0, mk(32'h1122_3344, 2'd0, 1'b0, 1'b0, 32'h0));
    chk("full_pop_same_cycle", 32'(s_cmd_rdy), 32'd0);
    chk("third_rdy_after_pop", 32'(agu_cmd_ready), 32'd1);
    tick();
    chk("third_issued", 32'(s_cmd_rdy), 32'd1);
    chk("third_bus_addr", s_dcmd_addr, 32'h5008);
    agu_cmd_valid = 1'b0;
    lsu_o_ready = 1'b0;
    respond(32'hCAFE_F00D, 1'b0, mk(32'hCAFE_F00D, 2'd1, 1'b0, 1'b0, 32'h0));
    dbus_rsp_valid = 1'b1; dbus_rsp_rdata = 32'h0000_9A00; dbus_rsp_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_rsp_rdy", 32'(s_drsp_rdy), 32'd0);
      chk("hold_valid", 32'(lsu_o_valid), 32'd1);
      chk("hold_wdat", lsu_o_wbck_wdat, 32'hCAFE_F00D);
      chk("hold_itag", 32'(lsu_o_itag), 32'd1);
    end
    lsu_o_ready = 1'b1;
    respond(32'h0000_9A00, 1'b0, mk(model(32'h0000_9A00, 2'd1, 2'b00, 1'b1, 1'b1), 2'd2, 1'b0, 1'b0, 32'h0));
    tick(); tick();

    // Misaligned word
`ifdef LSU_MISALIGN_CHK_EN
    send_cmd(32'h6000, 1'b1, 32'h0, 4'h0, 2'b10, 1'b0, 2'd0);
    send_cmd(32'h4001, 1'b1, 32'h0, 4'h0, 2'b10, 1'b0, 2'd3);
    chk("mis_no_bus_cmd", 32'(s_dcmd_valid), 32'd0);
    p0 = pulses;
    respond(32'h0F0F_0F0F, 1'b0, mk(32'h0F0F_0F0F, 2'd0, 1'b0, 1'b0, 32'h0));
    exp_q.push_back(mk(32'h0, 2'd3, 1'b1, 1'b1, 32'h4001));
    tick(); tick(); tick();
    chk("mis_agu_rsp_pulses", 32'(pulses - p0), 32'd1);
`else
    send_cmd(32'h4001, 1'b1, 32'h0, 4'h0, 2'b10, 1'b0, 2'd3);
    chk("mis_goes_to_bus", 32'(s_dcmd_valid), 32'd1);
    chk("mis_bus_addr", s_dcmd_addr, 32'h4000);
    respond(32'h0F0F_0F0F, 1'b0, mk(32'h0F0F_0F0F, 2'd3, 1'b0, 1'b0, 32'h0));
    tick(); tick();
`endif

    // Reset with two outstanding, then a stale response
    send_cmd(32'h7000, 1'b1, 32'h0, 4'h0, 2'b10, 1'b0, 2'd1);
    send_cmd(32'h7004, 1'b1, 32'h0, 4'h0, 2'b10, 1'b0, 2'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", 32'(lsu_o_valid), 32'd0);
    chk("midrst_empty_rdy", 32'(agu_cmd_ready), 32'd1);
    p0 = pulses;
    dbus_rsp_valid = 1'b1; dbus_rsp_rdata = 32'hBAD0_BAD0; dbus_rsp_err = 1'b0;
    tick();
    dbus_rsp_valid = 1'b0;
    chk("stale_rsp_rdy", 32'(s_drsp_rdy), 32'd1);
    chk("stale_no_agu_rsp", 32'(pulses - p0), 32'd0);
    tick();
    chk("stale_no_wb", 32'(lsu_o_valid), 32'd0);
    send_cmd(32'h8000, 1'b1, 32'h0, 4'h0, 2'b00, 1'b0, 2'd0);
    send_cmd(32'h8001, 1'b1, 32'h0, 4'h0, 2'b00, 1'b1, 2'd1);
    respond(32'h0000_8081, 1'b0, mk(model(32'h0000_8081, 2'd0, 2'b00, 1'b0, 1'b1), 2'd0, 1'b0, 1'b0, 32'h0));
    respond(32'h0000_8081, 1'b0, mk(model(32'h0000_8081, 2'd1, 2'b00, 1'b1, 1'b1), 2'd1, 1'b0, 1'b0, 32'h0));
    tick(); tick();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
